// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler
//   Round-robin scheduler for a 1-to-N serial demultiplexer. A single upstream
//   valid/ready bit stream is handed to one destination channel at a time in
//   bursts of BURST items. After each burst (or an aborted one) the scheduler
//   re-arbitrates, starting the search one channel past the last grant.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   en         scheduler enable
//   chan_en    [N] per-channel enable mask
//   dst_ready  [N] per-channel consumer ready
//   in_valid   upstream item valid
//   data_in    upstream data bit
//   in_ready   upstream ready (combinational)
//   sel        [W] current demux select (registered)
//   out        [N] registered demux output, data_in routed to bit sel on a transfer
//   out_valid  [N] registered one-hot strobe of the channel that received an item
//   busy       high whenever the scheduler is not idle
module demux_rr_scheduler #(
  parameter int N     = 8,
  parameter int BURST = 4,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] chan_en,
  input  logic [N-1:0] dst_ready,
  input  logic         in_valid,
  input  logic         data_in,
  output logic         in_ready,
  output logic [W-1:0] sel,
  output logic [N-1:0] out,
  output logic [N-1:0] out_valid,
  output logic         busy
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    ptr_reg, ptr_next;
  logic [W-1:0]    sel_reg, sel_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [N-1:0]    out_reg, out_next;
  logic [N-1:0]    out_valid_reg, out_valid_next;

  logic [N-1:0]    elig;
  logic [N-1:0]    sel_onehot;
  logic [W-1:0]    sel_wrap;
  logic            found;
  logic [W-1:0]    grant;
  logic            xfer;

  for (genvar gi = 0; gi < N; gi++) begin : g_elig
    assign elig[gi] = chan_en[gi] & dst_ready[gi];
  end

  // Channel following the current select; compare against N-1 so that
  // non-power-of-two channel counts never produce an out-of-range value.
  assign sel_wrap = (sel_reg == W'(N - 1)) ? '0 : sel_reg + W'(1);

  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_reg] = 1'b1;
  end

  // Rotating search starting at ptr. Walking k from high to low lets the
  // smallest offset (closest to ptr) win without a break statement.
  always_comb begin
    logic [W:0]   sum;
    logic [W-1:0] cand;
    found = 1'b0;
    grant = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_reg} + (W+1)'(k);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      cand = sum[W-1:0];
      if (elig[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign in_ready = (state_reg == XFER) & dst_ready[sel_reg] & chan_en[sel_reg] & en;
  assign xfer     = in_ready & in_valid;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    sel_next       = sel_reg;
    cnt_next       = cnt_reg;
    out_next       = '0;
    out_valid_next = '0;
    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = ARB;
        end
      end
      ARB: begin
        if (!en) begin
          state_next = IDLE;
        end else if (found) begin
          sel_next   = grant;
          cnt_next   = '0;
          state_next = XFER;
        end
      end
      XFER: begin
        if (!en) begin
          state_next = IDLE;
          ptr_next   = sel_wrap;
        end else if (!chan_en[sel_reg]) begin
          // Channel withdrawn mid-burst: drop the remainder and move on.
          state_next = ARB;
          ptr_next   = sel_wrap;
        end else if (xfer) begin
          out_valid_next = sel_onehot;
          out_next       = data_in ? sel_onehot : '0;
          if (cnt_reg == CW'(BURST - 1)) begin
            cnt_next   = '0;
            ptr_next   = sel_wrap;
            state_next = ARB;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        // Otherwise a stalled consumer: hold everything, no timeout.
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      sel_reg       <= '0;
      cnt_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      sel_reg       <= sel_next;
      cnt_reg       <= cnt_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign sel       = sel_reg;
  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler
//   Directed bench for demux_rr_scheduler (N=8, BURST=2). A cycle-level model
//   built from the scheduling rules (modular pointer arithmetic, simple phase
//   variable) is compared against every DUT output on each falling edge, and
//   hand-computed literal expectations pin key points of each scenario.
module tb_demux_rr_scheduler;

  localparam int N     = 8;
  localparam int BURST = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] chan_en;
  logic [N-1:0] dst_ready;
  logic         in_valid;
  logic         data_in;
  logic         in_ready;
  logic [2:0]   sel;
  logic [N-1:0] out;
  logic [N-1:0] out_valid;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  demux_rr_scheduler #(.N(N), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .chan_en   (chan_en),
    .dst_ready (dst_ready),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 arbitrating, 2 delivering a burst
  int           m_phase = 0;
  int           m_ptr   = 0;
  int           m_sel   = 0;
  int           m_done  = 0;
  logic [N-1:0] m_out   = '0;
  logic [N-1:0] m_ov    = '0;

  initial begin
    forever begin
      @(negedge clk);
      begin
        logic exp_rdy;
        exp_rdy = (m_phase == 2) && dst_ready[m_sel] && chan_en[m_sel] && en;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        chk("sel", {29'b0, sel}, m_sel);
        chk("out", {24'b0, out}, {24'b0, m_out});
        chk("out_valid", {24'b0, out_valid}, {24'b0, m_ov});
        chk("busy", {31'b0, busy}, {31'b0, (m_phase != 0)});
        chk("onehot", {31'b0, $countones(out_valid) <= 1}, 32'd1);
        chk("out_in_valid", {24'b0, out & ~out_valid}, 32'd0);
        if (out_valid != '0) begin
          $display("xfer t=%0t out_valid=%02h out=%02h sel=%0d", $time, out_valid, out, sel);
        end
        // advance the model across the coming rising edge
        m_out = '0;
        m_ov  = '0;
        if (rst) begin
          m_phase = 0; m_ptr = 0; m_sel = 0; m_done = 0;
        end else if (m_phase == 0) begin
          if (en) m_phase = 1;
        end else if (m_phase == 1) begin
          if (!en) begin
            m_phase = 0;
          end else begin
            for (int k = 0; k < N; k++) begin
              int c;
              c = (m_ptr + k) % N;
              if (chan_en[c] && dst_ready[c]) begin
                m_sel = c; m_done = 0; m_phase = 2;
                break;
              end
            end
          end
        end else begin
          if (!en) begin
            m_phase = 0; m_ptr = (m_sel + 1) % N;
          end else if (!chan_en[m_sel]) begin
            m_phase = 1; m_ptr = (m_sel + 1) % N;
          end else if (dst_ready[m_sel] && in_valid) begin
            m_ov  = N'(1) << m_sel;
            m_out = data_in ? m_ov : '0;
            m_done++;
            if (m_done == BURST) begin
              m_done = 0; m_ptr = (m_sel + 1) % N; m_phase = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rr_exp [17];
    int         skip_exp [5];
    logic [7:0] seen_q [$];
    int         grant_q [$];
    logic [7:0] prev;

    rr_exp   = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08,
                 8'h10, 8'h10, 8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80, 8'h01};
    skip_exp = '{0, 2, 5, 7, 0};

    rst = 1'b1; en = 1'b0; chan_en = 8'hFF; dst_ready = 8'hFF;
    in_valid = 1'b1; data_in = 1'b1;

    // reset / idle
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      chk("rst_out_valid", {24'b0, out_valid}, 32'd0);
      chk("rst_sel", {29'b0, sel}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    end
    rst = 1'b0;
    cyc(1);

    // round robin over all eight channels
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (out_valid != '0) seen_q.push_back(out_valid);
    end
    chk("rr_count_ge17", {31'b0, seen_q.size() >= 17}, 32'd1);
    for (int i = 0; i < 17 && i < seen_q.size(); i++) begin
      chk($sformatf("rr_seq%0d", i), {24'b0, seen_q[i]}, {24'b0, rr_exp[i]});
    end

    // skip ineligible channels
    do_reset();
    chan_en = 8'b1010_0101; en = 1'b1;
    prev = '0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      chk("skip_mask", {24'b0, out_valid & 8'h5A}, 32'd0);
      if (out_valid != '0 && prev == '0) begin
        for (int c = 0; c < N; c++) if (out_valid[c]) grant_q.push_back(c);
      end
      prev = out_valid;
    end
    chk("skip_count_ge5", {31'b0, grant_q.size() >= 5}, 32'd1);
    for (int i = 0; i < 5 && i < grant_q.size(); i++) begin
      chk($sformatf("skip_grant%0d", i), grant_q[i], skip_exp[i]);
    end

    // stall on channel 3
    do_reset();
    chan_en = 8'h08; en = 1'b1;
    cyc(3);
    chk("stall_first", {24'b0, out_valid}, 32'h08);
    chk("stall_sel", {29'b0, sel}, 32'd3);
    dst_ready = 8'hF7;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      cyc(1);
      chk("stall_out_valid", {24'b0, out_valid}, 32'd0);
    end
    dst_ready = 8'hFF;
    #1;
    chk("resume_in_ready", {31'b0, in_ready}, 32'd1);
    cyc(1);
    chk("resume_item", {24'b0, out_valid}, 32'h08);
    cyc(1);
    chk("burst_end_bubble", {24'b0, out_valid}, 32'd0);

    // abort on channel 2, then disable mid-burst
    do_reset();
    chan_en = 8'hFC; en = 1'b1;
    cyc(3);
    chk("abort_first", {24'b0, out_valid}, 32'h04);
    chan_en = 8'hF8;
    cyc(1);
    chk("abort_no_item", {24'b0, out_valid}, 32'd0);
    cyc(1);
    chk("abort_next_sel", {29'b0, sel}, 32'd3);
    cyc(1);
    chk("abort_next_item", {24'b0, out_valid}, 32'h08);
    en = 1'b0;
    cyc(1);
    chk("dis_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("dis_out_valid", {24'b0, out_valid}, 32'd0);
      cyc(1);
    end

    // zero data, then reset mid-burst
    do_reset();
    chan_en = 8'h20; data_in = 1'b0; en = 1'b1;
    cyc(3);
    chk("zero_out", {24'b0, out}, 32'd0);
    chk("zero_out_valid", {24'b0, out_valid}, 32'h20);
    chk("zero_sel", {29'b0, sel}, 32'd5);
    rst = 1'b1;
    cyc(1);
    chk("midrst_out_valid", {24'b0, out_valid}, 32'd0);
    chk("midrst_sel", {29'b0, sel}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0; chan_en = 8'hFF; data_in = 1'b1;
    cyc(3);
    chk("restart_out_valid", {24'b0, out_valid}, 32'h01);
    chk("restart_out", {24'b0, out}, 32'h01);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
